// File: rtl/contador_rst_pkg.sv
// contador_rst_pkg: shared constants and types for the I2C bit-count sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package contador_rst_pkg;

    // Default counter geometry: 9-clock I2C byte frame (8 data bits + ACK)
    localparam int CONTADOR_RST_WIDTH_DEF = 4;
    localparam int CONTADOR_RST_MAX_DEF   = 9;

    // Count values the I2C slave model decodes
    localparam int I2C_RW_BIT_POS = 8;
    localparam int I2C_ACK_POS    = 9;

    typedef logic [CONTADOR_RST_WIDTH_DEF-1:0] cnt_t;

endpackage

// File: rtl/contador_rst.sv
// contador_rst: counts rising Clk edges 1..MAX and wraps to 1; 0 marks idle / just re-synchronised.
// Latency: Out updates on the rising Clk edge that samples En=1; Rst low clears Out asynchronously.
// Backpressure: none; En=0 holds the count. Optional macro CONTADOR_RST_TC_EN adds Tc and frame_q.
module contador_rst
    import contador_rst_pkg::*;
#(
    parameter int MAX   = CONTADOR_RST_MAX_DEF,
    parameter int WIDTH = CONTADOR_RST_WIDTH_DEF
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    output logic [WIDTH-1:0] Out
`ifdef CONTADOR_RST_TC_EN
    ,
    output logic             Tc
`endif
);

    // Reject terminal counts that cannot be represented or would never leave 0
    if (MAX < 1 || MAX > (2 ** WIDTH) - 1) begin : g_bad_max
        $fatal(1, "contador_rst: MAX=%0d illegal for WIDTH=%0d", MAX, WIDTH);
    end

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             at_max;

    assign at_max = (cnt_q == MAX_V);

    // Next count: advance when enabled, wrap MAX back to 1 so 0 is reachable only via reset
    always_comb begin
        cnt_d = cnt_q;
        if (En) begin
            if (at_max) begin
                cnt_d = ONE_V;
            end else begin
                cnt_d = cnt_q + ONE_V;
            end
        end
    end

    // Count register, cleared asynchronously on START / repeated START
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Out = cnt_q;

`ifdef CONTADOR_RST_TC_EN
    logic [WIDTH-1:0] frame_q;
    logic [WIDTH-1:0] frame_d;

    // Terminal flag straight from the register: high for the whole ACK slot, 0 while in reset
    assign Tc = at_max;

    // Frame count: one per completed frame, i.e. per enabled MAX->1 wrap
    always_comb begin
        frame_d = frame_q;
        if (En && at_max) begin
            frame_d = frame_q + ONE_V;
        end
    end

    // Frame counter register, cleared together with the bit count
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end
`endif

endmodule

// File: tb/tb_contador_rst.sv
// tb_contador_rst: directed checks of the bit-count sequencer (default MAX=9 and MAX=15 instances).
// Inputs change #1 after the rising edge; outputs are sampled at that same point.
module tb_contador_rst;
    import contador_rst_pkg::*;

    logic Clk;
    logic Rst;
    logic En;
    cnt_t Out;
    logic rst15;
    logic en15;
    cnt_t out15;
`ifdef CONTADOR_RST_TC_EN
    logic Tc;
    logic tc15;
`endif

    int total;
    int bad;

    contador_rst #(.MAX(9), .WIDTH(4)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .En  (En),
        .Out (Out)
`ifdef CONTADOR_RST_TC_EN
        ,
        .Tc  (Tc)
`endif
    );

    contador_rst #(.MAX(15), .WIDTH(4)) dut15 (
        .Clk (Clk),
        .Rst (rst15),
        .En  (en15),
        .Out (out15)
`ifdef CONTADOR_RST_TC_EN
        ,
        .Tc  (tc15)
`endif
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        Rst   = 1'b1;
        En    = 1'b0;
        rst15 = 1'b1;
        en15  = 1'b0;
        #2;
        Rst   = 1'b0;
        rst15 = 1'b0;
        #1;
        chk("reset_out", Out, 4'd0);
        chk("reset_out15", out15, 4'd0);
`ifdef CONTADOR_RST_TC_EN
        chk("reset_tc", {3'b0, Tc}, 4'd0);
        chk("reset_frame", dut.frame_q, 4'd0);
`endif
        // Edges while held in reset must not count
        En = 1'b1;
        edge1();
        chk("reset_hold", Out, 4'd0);

        // Release reset, count 1..9
        Rst = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            edge1();
            chk($sformatf("count_%0d", i), Out, 4'(i));
`ifdef CONTADOR_RST_TC_EN
            chk($sformatf("tc_at_%0d", i), {3'b0, Tc}, (i == 9) ? 4'd1 : 4'd0);
`endif
        end

        // Wrap skips 0
        edge1();
        chk("wrap_10", Out, 4'd1);
`ifdef CONTADOR_RST_TC_EN
        chk("frame_after_wrap", dut.frame_q, 4'd1);
`endif
        edge1();
        chk("wrap_11", Out, 4'd2);
        edge1();
        chk("run_3", Out, 4'd3);
        edge1();
        chk("run_4", Out, 4'd4);

        // Enable hold for 3 edges
        En = 1'b0;
        for (int i = 0; i < 3; i++) begin
            edge1();
            chk($sformatf("hold_%0d", i), Out, 4'd4);
        end
        En = 1'b1;
        edge1();
        chk("reenable_5", Out, 4'd5);
        edge1();
        chk("run_6", Out, 4'd6);

        // Asynchronous reset pulse of 5 time units between edges
        #1;
        Rst = 1'b0;
        #1;
        chk("async_rst_immediate", Out, 4'd0);
`ifdef CONTADOR_RST_TC_EN
        chk("async_rst_frame", dut.frame_q, 4'd0);
`endif
        #4;
        Rst = 1'b1;
        chk("async_rst_released", Out, 4'd0);
        edge1();
        chk("after_rst_1", Out, 4'd1);

        // Read frame: reset, 8 edges to R/W slot, 9th to ACK
        Rst = 1'b0;
        #2;
        Rst = 1'b1;
        for (int i = 0; i < 8; i++) edge1();
        chk("rw_slot", Out, 4'(I2C_RW_BIT_POS));
`ifdef CONTADOR_RST_TC_EN
        chk("rw_tc", {3'b0, Tc}, 4'd0);
`endif
        edge1();
        chk("ack_slot", Out, 4'(I2C_ACK_POS));
`ifdef CONTADOR_RST_TC_EN
        chk("ack_tc", {3'b0, Tc}, 4'd1);
`endif
        edge1();
        chk("after_ack_wrap", Out, 4'd1);

        // MAX=15 instance: full range then wrap to 1
        rst15 = 1'b1;
        en15  = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            edge1();
            chk($sformatf("max15_count_%0d", i), out15, 4'(i));
        end
        edge1();
        chk("max15_wrap", out15, 4'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
